vga_text_renderer: RTL and testbench

Pixel-generation stage that sits directly downstream of the horizontal/vertical sync generator. It consumes the beam position (hpos, vpos), display_on, hsync and vsync. From these it fetches character cells from an external synchronous character RAM and glyph rows from an external synchronous font ROM. It outputs 3-bit RGB with hsync/vsync re-aligned to the pixel pipeline, plus a blinking attribute and a hardware cursor.

---
 rtl/vga_text_renderer.sv | 175 +++++++++++++++++
 tb/tb_vga_text_renderer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vga_text_renderer.sv
// vga_text_renderer: text-mode pixel pipeline. It turns the beam position into a
// character-RAM fetch, then a font-ROM fetch, then one 3-bit RGB pixel. Sync
// signals are delayed to stay aligned with the pixel data. The block also
// provides a blink attribute driven by a frame counter and a hardware
// underline cursor.
module vga_text_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hpos,
    input  logic [15:0] vpos,
    input  logic        display_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] char_addr,
    input  logic [15:0] char_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        cursor_en,
    input  logic [7:0]  cursor_col,
    input  logic [7:0]  cursor_row,
    output logic [2:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [12:0] COLS_W    = 13'(COLS);
    localparam logic [11:0] ROWS_W    = 12'(ROWS);
    localparam logic [7:0]  FRAME_MAX = 8'(BLINK_FRAMES - 1);

    // Beam position decoded into cell coordinates
    logic [12:0] col;
    logic [11:0] row;
    logic [3:0]  scanline;
    logic        in_range;
    logic        cursor_hit;
    logic [12:0] addr_full;

    assign col        = hpos[15:3];
    assign row        = vpos[15:4];
    assign scanline   = vpos[3:0];
    assign in_range   = display_on && (col < COLS_W) && (row < ROWS_W);
    assign cursor_hit = cursor_en && (col == {5'b0, cursor_col})
                        && (row == {4'b0, cursor_row}) && (scanline >= 4'd14);
    // 13-bit address arithmetic, truncated to the 12-bit RAM address
    assign addr_full  = 13'(row) * COLS_W + col;

    // Attribute bit 14 carries nothing
    logic unused_attr;
    assign unused_attr = char_data[14];

    // Sideband delay lines; stage 5 is the output register itself
    logic [4:1][2:0] pix_sr;
    logic [4:1]      range_sr;
    logic [4:1]      cursor_sr;
    logic [4:1]      de_sr;
    logic [5:1]      hs_sr;
    logic [5:1]      vs_sr;
    logic [3:0]      scan1_reg, scan2_reg;

    // Attribute pipeline (S3 captures from RAM, S4 waits on ROM)
    logic [2:0] fg3_reg, bg3_reg, fg4_reg, bg4_reg;
    logic       blink3_reg, blink4_reg;

    // Blink timer
    logic       prev_vsync_reg;
    logic [7:0] frame_cnt_reg;
    logic       blink_phase_reg;

    logic [2:0] rgb_reg, rgb_next;
    logic       pixel_bit;

    // S1: character address and per-pixel sidebands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_addr <= 12'd0;
            scan1_reg <= 4'd0;
        end else begin
            char_addr <= in_range ? addr_full[11:0] : 12'd0;
            scan1_reg <= scanline;
        end
    end

    // Sideband shift registers, one stage per pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_sr    <= '0;
            range_sr  <= '0;
            cursor_sr <= '0;
            de_sr     <= '0;
            hs_sr     <= '0;
            vs_sr     <= '0;
            scan2_reg <= 4'd0;
        end else begin
            pix_sr    <= {pix_sr[3:1], hpos[2:0]};
            range_sr  <= {range_sr[3:1], in_range};
            cursor_sr <= {cursor_sr[3:1], cursor_hit};
            de_sr     <= {de_sr[3:1], display_on};
            hs_sr     <= {hs_sr[4:1], hsync_in};
            vs_sr     <= {vs_sr[4:1], vsync_in};
            scan2_reg <= scan1_reg;
        end
    end

    // S3 captures RAM data and issues the font address; S4 holds attributes for the ROM cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            font_addr  <= 12'd0;
            fg3_reg    <= 3'd0;
            bg3_reg    <= 3'd0;
            blink3_reg <= 1'b0;
            fg4_reg    <= 3'd0;
            bg4_reg    <= 3'd0;
            blink4_reg <= 1'b0;
        end else begin
            font_addr  <= {char_data[7:0], scan2_reg};
            fg3_reg    <= char_data[10:8];
            bg3_reg    <= char_data[13:11];
            blink3_reg <= char_data[15];
            fg4_reg    <= fg3_reg;
            bg4_reg    <= bg3_reg;
            blink4_reg <= blink3_reg;
        end
    end

    // Frame counter advanced by vsync falling edges; toggles blink phase on wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_vsync_reg  <= 1'b0;
            frame_cnt_reg   <= 8'd0;
            blink_phase_reg <= 1'b0;
        end else begin
            prev_vsync_reg <= vsync_in;
            if (prev_vsync_reg && !vsync_in) begin
                if (frame_cnt_reg == FRAME_MAX) begin
                    frame_cnt_reg   <= 8'd0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign pixel_bit = font_data[3'd7 - pix_sr[4]];

    // Pixel colour: blanking, then cursor, then blink, then glyph
    always_comb begin
        rgb_next = 3'b000;
        if (range_sr[4] && de_sr[4]) begin
            if (cursor_sr[4] && !blink_phase_reg)
                rgb_next = fg4_reg;
            else if (blink4_reg && blink_phase_reg)
                rgb_next = bg4_reg;
            else
                rgb_next = pixel_bit ? fg4_reg : bg4_reg;
        end
    end

    // S5: output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgb_reg <= 3'b000;
        else
            rgb_reg <= rgb_next;
    end

    assign rgb       = rgb_reg;
    assign hsync_out = hs_sr[5];
    assign vsync_out = vs_sr[5];

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer with behavioural RAM/ROM models.
module tb_vga_text_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] hpos, vpos;
    logic        display_on, hsync_in, vsync_in;
    logic [11:0] char_addr, font_addr;
    logic [15:0] char_data;
    logic [7:0]  font_data;
    logic        cursor_en;
    logic [7:0]  cursor_col, cursor_row;
    logic [2:0]  rgb;
    logic        hsync_out, vsync_out;

    logic [15:0] ram [0:4095];
    logic [7:0]  rom [0:4095];

    int checks = 0;
    int errors = 0;

    int exp_rgb [8] = '{0, 0, 0, 7, 7, 0, 0, 0};
    int exp_hs  [8] = '{0, 0, 1, 1, 0, 0, 1, 0};

    vga_text_renderer #(.COLS(80), .ROWS(30), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memories with registered read
    always @(posedge clk) begin
        char_data <= ram[char_addr];
        font_data <= rom[font_addr];
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one beam position for the full latency and check the resulting colour
    task automatic check_pixel(input string tag, input int h, input int v, input logic de,
                               input logic [2:0] exp);
        hpos       = 16'(h);
        vpos       = 16'(v);
        display_on = de;
        repeat (5) tick();
        check_value(tag, {29'd0, rgb}, {29'd0, exp});
    endtask

    // One vsync low pulse of the given length
    task automatic frame_event(input int low_len);
        vsync_in = 1'b0;
        repeat (low_len) tick();
        vsync_in = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 16'h0000;
            rom[i] = 8'h00;
        end
        ram[0]        = 16'h0741;
        ram[1]        = 16'h8F41;
        ram[163]      = 16'h0341;
        ram[2399]     = 16'h2A41;
        rom[12'h410]  = 8'h18;
        rom[12'h41D]  = 8'h00;
        rom[12'h41E]  = 8'h40;
        rom[12'h41F]  = 8'h40;

        reset      = 1'b1;
        hpos       = 16'd0;
        vpos       = 16'd0;
        display_on = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        cursor_en  = 1'b0;
        cursor_col = 8'd3;
        cursor_row = 8'd2;
        repeat (3) tick();
        check_value("reset_rgb", {29'd0, rgb}, 32'd0);
        check_value("reset_hsync", {31'd0, hsync_out}, 32'd0);
        check_value("reset_vsync", {31'd0, vsync_out}, 32'd0);
        check_value("reset_char_addr", {20'd0, char_addr}, 32'd0);
        check_value("reset_font_addr", {20'd0, font_addr}, 32'd0);
        reset = 1'b0;

        // Mid-stream reset: build up a lit pixel, then reset asynchronously
        check_pixel("pre_reset_rgb", 3, 0, 1'b1, 3'd7);
        check_value("pre_reset_hsync", {31'd0, hsync_out}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_value("async_reset_rgb", {29'd0, rgb}, 32'd0);
        check_value("async_reset_hsync", {31'd0, hsync_out}, 32'd0);
        check_value("async_reset_vsync", {31'd0, vsync_out}, 32'd0);
        check_value("async_reset_font_addr", {20'd0, font_addr}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_value($sformatf("post_reset_rgb_c%0d", c), {29'd0, rgb}, 32'd0);
        end
        tick();
        check_value("post_reset_rgb_c5", {29'd0, rgb}, 32'd7);

        // Streaming glyph row: hpos 0..7 of cell (0,0), varying hsync
        for (int j = 0; j < 12; j++) begin
            if (j < 8) begin
                hpos       = 16'(j);
                vpos       = 16'd0;
                display_on = 1'b1;
                hsync_in   = (j == 2 || j == 3 || j == 6);
            end else begin
                hpos       = 16'd640;
                display_on = 1'b0;
                hsync_in   = 1'b0;
            end
            tick();
            if (j == 0) check_value("stream_char_addr", {20'd0, char_addr}, 32'd0);
            if (j == 2) check_value("stream_font_addr", {20'd0, font_addr}, 32'h410);
            if (j == 4) check_value("stream_vsync_out", {31'd0, vsync_out}, 32'd1);
            if (j >= 4) begin
                check_value($sformatf("stream_rgb_h%0d", j - 4), {29'd0, rgb}, 32'(exp_rgb[j - 4]));
                check_value($sformatf("stream_hsync_h%0d", j - 4), {31'd0, hsync_out}, 32'(exp_hs[j - 4]));
            end
        end
        hsync_in = 1'b1;

        // Last cell of the screen
        check_pixel("last_cell_rgb", 79 * 8, 29 * 16, 1'b1, 3'd5);
        check_value("last_cell_char_addr", {20'd0, char_addr}, 32'd2399);

        // Blanking: display_on low, then column past the end with display_on high
        check_pixel("blank_display_off", 643, 0, 1'b0, 3'd0);
        check_pixel("blank_col_81", 651, 0, 1'b1, 3'd0);
        check_value("blank_char_addr", {20'd0, char_addr}, 32'd0);

        // Blink cell at (1,0): fg 7, bg 1
        check_pixel("blink_e0_fg", 11, 0, 1'b1, 3'd7);
        check_pixel("blink_e0_bg_px", 8, 0, 1'b1, 3'd1);
        frame_event(1);
        check_pixel("blink_e1", 11, 0, 1'b1, 3'd7);
        frame_event(3);
        check_pixel("blink_e2", 11, 0, 1'b1, 3'd1);
        frame_event(1);
        check_pixel("blink_e3", 11, 0, 1'b1, 3'd1);
        frame_event(2);
        check_pixel("blink_e4", 11, 0, 1'b1, 3'd7);

        // Cursor at column 3, row 2 (cell fg 3, bg 0)
        cursor_en = 1'b1;
        check_pixel("cursor_p0_s14", 24, 46, 1'b1, 3'd3);
        check_pixel("cursor_p0_s15", 24, 47, 1'b1, 3'd3);
        check_pixel("cursor_p0_s13", 24, 45, 1'b1, 3'd0);
        cursor_en = 1'b0;
        check_pixel("cursor_off_s14", 24, 46, 1'b1, 3'd0);
        cursor_en = 1'b1;
        frame_event(1);
        frame_event(1);
        check_pixel("cursor_p1_s14_px0", 24, 46, 1'b1, 3'd0);
        check_pixel("cursor_p1_s14_px1", 25, 46, 1'b1, 3'd3);
        check_pixel("cursor_p1_s13", 24, 45, 1'b1, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
